// File: rtl/channel_arbiter_if.sv
// Bundle of the arbiter's per-port input channels and its single output channel.
// A word moves on a channel in any cycle where its valid and ready are both high;
// valid never waits on ready, and a held word keeps its payload stable until taken.
interface channel_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int PORTS = 2
);
    logic [PORTS*WIDTH-1:0] idata;
    logic [PORTS-1:0]       ivalid;
    logic [PORTS-1:0]       iready;
    logic [WIDTH-1:0]       odata;
    logic                   ovalid;
    logic                   oready;
    logic [PORTS-1:0]       ogrant;

    modport master (
        output idata, ivalid, oready,
        input  iready, odata, ovalid, ogrant
    );

    modport slave (
        input  idata, ivalid, oready,
        output iready, odata, ovalid, ogrant
    );
endinterface

// File: rtl/channel_arbiter.sv
// Round-robin N:1 channel arbiter with bounded bursts and a single registered output stage.
// Arbitration state (last served port, burst length) is exposed on debug outputs.
module channel_arbiter #(
    parameter int WIDTH = 8,
    parameter int PORTS = 2,
    parameter int BURST = 1,
    localparam int LW = $clog2(PORTS),
    localparam int CW = $clog2(BURST + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    channel_arbiter_if.slave  bus,
    output logic [LW-1:0]     dbg_last_o,
    output logic [CW-1:0]     dbg_cnt_o
);

    logic [LW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic             ovalid_q, ovalid_d;
    logic [PORTS-1:0] ogrant_q, ogrant_d;
    // Low from reset until the first clock edge so nothing is accepted in between.
    logic             run_q;

    logic             ld;
    logic             any_valid;
    logic             sticky;
    logic             xfer;
    logic             found;
    int               rot_sum;
    logic [LW-1:0]    rot_idx;
    logic [LW-1:0]    sel;
    logic [PORTS-1:0] sel_oh;

    assign ld        = !ovalid_q || bus.oready;
    assign any_valid = |bus.ivalid;
    assign xfer      = run_q && ld && any_valid;

    always_comb begin
        sticky  = (cnt_q != '0) && (cnt_q < CW'(BURST)) && bus.ivalid[last_q];
        sel     = last_q;
        found   = 1'b0;
        rot_sum = 0;
        rot_idx = '0;
        for (int k = 1; k <= PORTS; k++) begin
            rot_sum = int'(last_q) + k;
            if (rot_sum >= PORTS) rot_sum = rot_sum - PORTS;
            rot_idx = LW'(rot_sum);
            if (!found && bus.ivalid[rot_idx]) begin
                sel   = rot_idx;
                found = 1'b1;
            end
        end
        if (sticky) sel = last_q;
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    assign bus.iready = xfer ? sel_oh : '0;

    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        ogrant_d = ogrant_q;
        if (ld) begin
            if (xfer) begin
                odata_d  = bus.idata[sel*WIDTH +: WIDTH];
                ovalid_d = 1'b1;
                ogrant_d = sel_oh;
                last_d   = sel;
                // A lone requester can win the rotation back; saturate so cnt stays within BURST.
                if ((sel == last_q) && (cnt_q != '0))
                    cnt_d = (cnt_q == CW'(BURST)) ? cnt_q : cnt_q + 1'b1;
                else
                    cnt_d = CW'(1);
            end else begin
                ovalid_d = 1'b0;
                ogrant_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_q   <= LW'(PORTS - 1);
            cnt_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ogrant_q <= '0;
            run_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ogrant_q <= ogrant_d;
            run_q    <= 1'b1;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.ogrant = ogrant_q;
    assign dbg_last_o = last_q;
    assign dbg_cnt_o  = cnt_q;

    a_iready_onehot0: assert property (@(posedge clock) disable iff (!resetn)
        $onehot0(bus.iready));
    a_grant_shape: assert property (@(posedge clock) disable iff (!resetn)
        ovalid_q ? $onehot(ogrant_q) : (ogrant_q == '0));
    a_stall_hold: assert property (@(posedge clock) disable iff (!resetn)
        (ovalid_q && !bus.oready) |=> (ovalid_q && $stable(odata_q) && $stable(ogrant_q)));
    a_cnt_range: assert property (@(posedge clock) disable iff (!resetn)
        cnt_q <= CW'(BURST));

endmodule

// File: tb/tb_channel_arbiter.sv
// Bench for channel_arbiter: two instances (BURST=1 and BURST=3) driven with the same valid/ready
// pattern, each checked every cycle against a rule-level reference model and literal sequences.
module tb_channel_arbiter;
    localparam int W = 8;
    localparam int P = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    channel_arbiter_if #(.WIDTH(W), .PORTS(P)) bus_a ();
    channel_arbiter_if #(.WIDTH(W), .PORTS(P)) bus_b ();

    logic [0:0] dbg_last_a, dbg_last_b, dbg_cnt_a;
    logic [1:0] dbg_cnt_b;

    channel_arbiter #(.WIDTH(W), .PORTS(P), .BURST(1)) dut_a (
        .clock(clock), .resetn(resetn), .bus(bus_a),
        .dbg_last_o(dbg_last_a), .dbg_cnt_o(dbg_cnt_a)
    );
    channel_arbiter #(.WIDTH(W), .PORTS(P), .BURST(3)) dut_b (
        .clock(clock), .resetn(resetn), .bus(bus_b),
        .dbg_last_o(dbg_last_b), .dbg_cnt_o(dbg_cnt_b)
    );

    logic [P*W-1:0] idata_drv[2];
    logic [P-1:0]   ivalid_drv[2];
    logic           oready_drv[2];
    assign bus_a.idata  = idata_drv[0];
    assign bus_a.ivalid = ivalid_drv[0];
    assign bus_a.oready = oready_drv[0];
    assign bus_b.idata  = idata_drv[1];
    assign bus_b.ivalid = ivalid_drv[1];
    assign bus_b.oready = oready_drv[1];

    logic [P-1:0] iready_obs[2];
    logic [W-1:0] odata_obs[2];
    logic         ovalid_obs[2];
    logic [P-1:0] ogrant_obs[2];
    logic [3:0]   last_obs[2];
    logic [3:0]   cnt_obs[2];
    assign iready_obs[0] = bus_a.iready;
    assign iready_obs[1] = bus_b.iready;
    assign odata_obs[0]  = bus_a.odata;
    assign odata_obs[1]  = bus_b.odata;
    assign ovalid_obs[0] = bus_a.ovalid;
    assign ovalid_obs[1] = bus_b.ovalid;
    assign ogrant_obs[0] = bus_a.ogrant;
    assign ogrant_obs[1] = bus_b.ogrant;
    assign last_obs[0]   = 4'(dbg_last_a);
    assign last_obs[1]   = 4'(dbg_last_b);
    assign cnt_obs[0]    = 4'(dbg_cnt_a);
    assign cnt_obs[1]    = 4'(dbg_cnt_b);

    int checks   = 0;
    int failures = 0;

    // Reference model state, per instance.
    int           m_last[2];
    int           m_cnt[2];
    int           m_seq[2][P];
    int           m_wait[2][P];
    logic [W-1:0] m_odata[2];
    bit           m_ovalid[2];
    logic [P-1:0] m_ogrant[2];
    bit           m_run[2];
    int           e_sel[2];

    logic [W+P-1:0] exp_qa[$];
    logic [W+P-1:0] exp_qb[$];

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic int burst_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [W-1:0] word(input int i, input int p);
        return W'(8'h10 + 16 * p + m_seq[i][p]);
    endfunction

    function automatic logic [P-1:0] onehot(input int p);
        logic [P-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // Winner per the arbitration rules: burst continuation, else nearest valid port after last.
    function automatic int model_sel(input int i, input logic [P-1:0] v);
        int best, bestd, d;
        if (!m_run[i] || (m_ovalid[i] && !oready_drv[i]) || (v == '0)) return -1;
        if (m_cnt[i] > 0 && m_cnt[i] < burst_of(i) && v[m_last[i]]) return m_last[i];
        best  = -1;
        bestd = P;
        for (int p = 0; p < P; p++) begin
            d = (p - m_last[i] - 1 + P) % P;
            if (v[p] && d < bestd) begin
                bestd = d;
                best  = p;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i]   = P - 1;
            m_cnt[i]    = 0;
            m_odata[i]  = '0;
            m_ovalid[i] = 1'b0;
            m_ogrant[i] = '0;
            m_run[i]    = 1'b0;
            for (int p = 0; p < P; p++) m_wait[i][p] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_odata"},  i, 32'(odata_obs[i]),  32'(m_odata[i]));
            check({tag, "_ovalid"}, i, 32'(ovalid_obs[i]), 32'(m_ovalid[i]));
            check({tag, "_ogrant"}, i, 32'(ogrant_obs[i]), 32'(m_ogrant[i]));
            check({tag, "_last"},   i, 32'(last_obs[i]),   32'(m_last[i]));
            check({tag, "_cnt"},    i, 32'(cnt_obs[i]),    32'(m_cnt[i]));
        end
    endtask

    // One clock cycle: drive just after the falling edge, check iready, then outputs after the rise.
    task automatic step(input logic [P-1:0] v, input bit ordy, input bit rec);
        logic [W+P-1:0] e;
        bit loaded;
        for (int i = 0; i < 2; i++) begin
            ivalid_drv[i] = v;
            oready_drv[i] = ordy;
            for (int p = 0; p < P; p++) idata_drv[i][p*W +: W] = word(i, p);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            e_sel[i] = model_sel(i, v);
            check("iready", i, 32'(iready_obs[i]), (e_sel[i] < 0) ? 32'd0 : 32'(onehot(e_sel[i])));
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            loaded = 1'b0;
            if (!m_run[i]) begin
                m_run[i] = 1'b1;
            end else if (!(m_ovalid[i] && !ordy)) begin
                if (e_sel[i] >= 0) begin
                    m_odata[i]  = word(i, e_sel[i]);
                    m_ovalid[i] = 1'b1;
                    m_ogrant[i] = onehot(e_sel[i]);
                    if (e_sel[i] == m_last[i] && m_cnt[i] > 0)
                        m_cnt[i] = (m_cnt[i] + 1 > burst_of(i)) ? burst_of(i) : m_cnt[i] + 1;
                    else
                        m_cnt[i] = 1;
                    m_last[i] = e_sel[i];
                    m_seq[i][e_sel[i]]++;
                    loaded = 1'b1;
                end else begin
                    m_ovalid[i] = 1'b0;
                    m_ogrant[i] = '0;
                end
            end
            if (loaded) begin
                for (int p = 0; p < P; p++) begin
                    if (ogrant_obs[i][p] || !v[p]) m_wait[i][p] = 0;
                    else m_wait[i][p]++;
                    if (v[p]) check("starve", i, 32'(m_wait[i][p] <= (P - 1) * burst_of(i)), 32'd1);
                end
            end
            if (rec && ovalid_obs[i]) begin
                if (i == 0 && exp_qa.size() > 0) begin
                    e = exp_qa.pop_front();
                    check("seq", i, 32'({ogrant_obs[i], odata_obs[i]}), 32'(e));
                end
                if (i == 1 && exp_qb.size() > 0) begin
                    e = exp_qb.pop_front();
                    check("seq", i, 32'({ogrant_obs[i], odata_obs[i]}), 32'(e));
                end
            end
        end
        check_outputs("out");
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ivalid_drv[i] = 2'b11;
            oready_drv[i] = 1'b1;
            idata_drv[i]  = '0;
            for (int p = 0; p < P; p++) m_seq[i][p] = 0;
        end
        model_reset();

        // Reset state, with requests already pending.
        #12;
        for (int i = 0; i < 2; i++) check("reset_iready", i, 32'(iready_obs[i]), 32'd0);
        check_outputs("reset");
        @(negedge clock);
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("post_release_iready", i, 32'(iready_obs[i]), 32'd0);

        // Both ports saturated: alternation for BURST=1, bursts of 3 for BURST=3.
        exp_qa = '{{2'b01, 8'h10}, {2'b10, 8'h20}, {2'b01, 8'h11}, {2'b10, 8'h21},
                   {2'b01, 8'h12}, {2'b10, 8'h22}, {2'b01, 8'h13}};
        exp_qb = '{{2'b01, 8'h10}, {2'b01, 8'h11}, {2'b01, 8'h12}, {2'b10, 8'h20},
                   {2'b10, 8'h21}, {2'b10, 8'h22}, {2'b01, 8'h13}};
        for (int s = 0; s < 8; s++) step(2'b11, 1'b1, 1'b1);
        check("seq_left", 0, 32'(exp_qa.size()), 32'd0);
        check("seq_left", 1, 32'(exp_qb.size()), 32'd0);

        // Downstream stall for 4 cycles, then release.
        for (int s = 0; s < 4; s++) step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);

        // Requester drops mid-burst, then comes back.
        step(2'b01, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) step(2'b11, 1'b1, 1'b0);

        // Single requester at full rate.
        for (int s = 0; s < 6; s++) step(2'b10, 1'b1, 1'b0);

        // Idle gap.
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);

        // Randomized traffic and backpressure.
        for (int s = 0; s < 400; s++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'b0);

        // Asynchronous reset while holding a word.
        step(2'b11, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_ovalid", i, 32'(ovalid_obs[i]), 32'd0);
            check("async_ogrant", i, 32'(ogrant_obs[i]), 32'd0);
            check("async_iready", i, 32'(iready_obs[i]), 32'd0);
        end
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        step(2'b11, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) check("first_grant", i, 32'(ogrant_obs[i]), 32'd1);
        for (int s = 0; s < 4; s++) step(2'b11, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter PORTS, default 2, legal 2..8: number of input channels.
REQ-003 Parameter BURST, default 1, legal 1..15: max consecutive transfers granted to one input before rotating.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 idata  input  PORTS*WIDTH  input payloads; port i occupies bits [i*WIDTH +: WIDTH].
REQ-007 ivalid  input  PORTS  per-port valid.
REQ-008 iready  output  PORTS  per-port ready; at most one bit high per cycle.
REQ-009 odata  output  WIDTH  registered output payload.
REQ-010 ovalid  output  1  registered output valid.
REQ-011 oready  input  1  downstream ready.
REQ-012 ogrant  output  PORTS  one-hot source port of the word in odata; all-zero when ovalid=0.

Function
REQ-013 Transfer on a port occurs in a cycle where its valid and ready are both high; same for output (ovalid && oready).
REQ-014 Output stage is a single register; load enable ld = !ovalid || oready.
REQ-015 iready[i] = ld && (sel == i) && ivalid[i]; iready shall be combinational from ivalid, oready and internal state only, with no dependence on idata.
REQ-016 State: last (index of last served port), cnt (0..BURST, consecutive transfers from last).
REQ-017 Selection, sticky: if cnt > 0, cnt < BURST and ivalid[last], sel = last.
REQ-018 Selection, rotate: otherwise sel = first port with ivalid set, searching last+1, last+2, ... modulo PORTS, ending at last.
REQ-019 No port valid: no iready asserted, state unchanged.
REQ-020 On input transfer from sel: odata <= idata[sel], ovalid <= 1, ogrant <= one-hot(sel), last <= sel; cnt <= cnt+1 if sel == last and cnt > 0, else cnt <= 1.
REQ-021 If ld and no input transfer: ovalid <= 0, ogrant <= 0; odata holds.
REQ-022 If !ld (ovalid && !oready): odata, ovalid, ogrant, last and cnt hold; all iready low.
REQ-023 Latency: one cycle, input transfer in cycle n -> ovalid in cycle n+1.
REQ-024 Throughput: one word per cycle sustained while oready=1.
REQ-025 Simultaneous output consume and input accept in the same cycle shall be lossless: new word replaces old, ovalid stays 1.
REQ-026 A requester that drops ivalid mid-burst forfeits its remaining burst; the next selection rotates per REQ-018.
REQ-027 Starvation bound: a port held valid is granted within (PORTS-1)*BURST input transfers.
REQ-028 Data order per port preserved; no word duplicated or dropped.

Reset
REQ-029 While resetn=0: ovalid=0, ogrant=0, odata=0, iready=0, last=PORTS-1, cnt=0 (port 0 highest priority after reset).
REQ-030 Reset assertion mid-transfer discards the output word; no iready after deassertion until the first rising edge.

Verification
REQ-031 PORTS=2, BURST=1, both ivalid=1, oready=1, port0 sends 0x10,0x11,..., port1 sends 0x20,0x21,... -> odata 0x10,0x20,0x11,0x21 on consecutive cycles, ogrant 01,10,01,10.
REQ-032 PORTS=2, BURST=3, both valid, oready=1 -> odata 0x10,0x11,0x12,0x20,0x21,0x22,0x13.
REQ-033 BURST=3, port0 drops ivalid after 0x10 while port1 is valid -> next word 0x20; port0 reasserts -> served after port1's burst of 3.
REQ-034 oready=0 for 4 cycles with ovalid=1, odata=0x10 -> odata/ogrant stable, iready=00, no input consumed; oready=1 -> 0x10 accepted, next word loaded the same cycle.
REQ-035 Only port1 valid from reset, oready=1 -> iready=10 every cycle, odata 0x20,0x21,... at full rate, ovalid=1 from cycle 2.
REQ-036 resetn pulsed low while ovalid=1 -> ovalid=0, ogrant=0 immediately; after release, first grant goes to port0 if both are valid.
